// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data memory with byte lanes, extended sub-word loads,
// address exceptions, and a sequential clear engine that runs after reset.
// Ports:
//   Clock, Reset (sync, active-low)
//   Req/Ready handshake
//   WE, Size, SignRead, Addr, WD, WPC request fields
//   RD/RValid registered load result
//   AdEL/AdES address error pulses
//   Busy while the clear engine owns the array
module dm_ctrl #(
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter bit          TRACE_EN   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  output logic        Ready,
  input  logic        WE,
  input  logic [1:0]  Size,
  input  logic        SignRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [31:0] WPC,
  output logic [31:0] RD,
  output logic        RValid,
  output logic        AdEL,
  output logic        AdES,
  output logic        Busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rd_q, rd_d;
  logic            rvalid_q, rvalid_d;
  logic            adel_q, adel_d;
  logic            ades_q, ades_d;

  logic [31:0]     mem [DEPTH];

  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            is_word;
  logic            is_half;
  logic            is_byte;
  logic            misal;
  logic            legal;
  logic            accept;
  logic            st_en;
  logic            clr_en;
  logic [3:0]      lane;
  logic [31:0]     wdat;
  logic [31:0]     old;
  logic [31:0]     merged;
  logic [31:0]     ld_sh;
  logic [31:0]     ld_ext;

  assign Ready  = (state_q == S_IDLE);
  assign Busy   = (state_q == S_CLEAR);
  assign RD     = rd_q;
  assign RValid = rvalid_q;
  assign AdEL   = adel_q;
  assign AdES   = ades_q;

  // Unsigned wrap makes addresses below the base fall out of range.
  assign off      = Addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign in_range = (off >> (AW + 2)) == 32'd0;
  assign is_word  = (Size == 2'd0) || (Size == 2'd3);
  assign is_half  = (Size == 2'd1);
  assign is_byte  = (Size == 2'd2);
  assign misal    = (is_word && (Addr[1:0] != 2'b00))
                 || (is_half && Addr[0]);
  assign legal    = in_range && !misal;
  assign accept   = Req && Ready;
  assign st_en    = accept && WE && legal;
  assign clr_en   = (state_q == S_CLEAR);

  assign old   = mem[idx];
  assign wdat  = WD << {Addr[1:0], 3'b000};
  assign ld_sh = old >> {Addr[1:0], 3'b000};

  always_comb begin
    lane = 4'b0001 << Addr[1:0];
    unique case (1'b1)
      is_word: lane = 4'b1111;
      is_half: lane = 4'b0011 << Addr[1:0];
      is_byte: lane = 4'b0001 << Addr[1:0];
    endcase
  end

  always_comb begin
    merged = old;
    for (int b = 0; b < 4; b++) begin
      if (lane[b]) merged[8*b +: 8] = wdat[8*b +: 8];
    end
  end

  always_comb begin
    ld_ext = ld_sh;
    unique case (1'b1)
      is_word: ld_ext = ld_sh;
      is_half: ld_ext = {{16{SignRead & ld_sh[15]}}, ld_sh[15:0]};
      is_byte: ld_ext = {{24{SignRead & ld_sh[7]}}, ld_sh[7:0]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rvalid_d = 1'b0;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          if (WE) begin
            ades_d = !legal;
          end else begin
            rvalid_d = 1'b1;
            adel_d   = !legal;
            rd_d     = legal ? ld_ext : 32'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
    end
  end

  // Array has no reset; the clear engine zeroes it one word per cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (clr_en) begin
        mem[cnt_q] <= '0;
      end else if (st_en) begin
        mem[idx] <= merged;
        if (TRACE_EN) begin
          $display("%d@%h: *%h <= %h", $time, WPC,
                   {Addr[31:2], 2'b00}, merged);
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: self-checking bench for dm_ctrl (DEPTH_LOG2=4, base 0)
// using a byte-addressed reference model and randomized traffic.
module tb_dm_ctrl;

  localparam int          DL    = 4;
  localparam int          DEPTH = 2 ** DL;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Req = 1'b0;
  logic        WE = 1'b0;
  logic [1:0]  Size = 2'd0;
  logic        SignRead = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WD = '0;
  logic [31:0] WPC = '0;
  logic        Ready;
  logic [31:0] RD;
  logic        RValid;
  logic        AdEL;
  logic        AdES;
  logic        Busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0]    mb [4*DEPTH];
  logic [31:0] last_rd = '0;

  dm_ctrl #(
    .DEPTH_LOG2(DL),
    .BASE_ADDR (BASE),
    .TRACE_EN  (1'b1)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Ready   (Ready),
    .WE      (WE),
    .Size    (Size),
    .SignRead(SignRead),
    .Addr    (Addr),
    .WD      (WD),
    .WPC     (WPC),
    .RD      (RD),
    .RValid  (RValid),
    .AdEL    (AdEL),
    .AdES    (AdES),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
    last_rd = '0;
  endtask

  // Byte-level reference: legality from size/offset arithmetic.
  task automatic model_op(input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic erv, output logic eadel,
                          output logic eades, output logic [31:0] erd);
    int n;
    longint off;
    bit ok;
    logic [31:0] v;
    n = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
    off = longint'(a) - longint'(BASE);
    ok = (off >= 0) && (off < 4*DEPTH) && ((a % n) == 0);
    erv = 1'b0;
    eadel = 1'b0;
    eades = 1'b0;
    erd = last_rd;
    if (we) begin
      if (ok) begin
        for (int i = 0; i < n; i++) mb[int'(off) + i] = wd[8*i +: 8];
      end else begin
        eades = 1'b1;
      end
    end else begin
      erv = 1'b1;
      if (!ok) begin
        eadel = 1'b1;
        erd = '0;
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mb[int'(off) + i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        erd = v;
      end
      last_rd = erd;
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    Req = 1'b1;
    WE = we;
    Size = sz;
    SignRead = sg;
    Addr = a;
    WD = wd;
    WPC = $urandom;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Req = 1'b0;
    @(posedge Clock);
    #1;
  endtask

  // Counts Busy cycles, the current sampled cycle included.
  task automatic busy_window(output int cnt);
    cnt = Busy ? 1 : 0;
    for (int k = 0; k < 100 && Busy; k++) begin
      @(posedge Clock);
      #1;
      if (Busy) cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic erv, eadel, eades;
    logic [31:0] erd;
    Req = 1'b0;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    n_tests++;
    if ({Busy, Ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_busy_ready got=%b want=10", {Busy, Ready});
    end
    n_tests++;
    if ({RValid, AdEL, AdES, RD} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rv=%b el=%b es=%b rd=%h want 0",
               RValid, AdEL, AdES, RD);
    end
    Reset = 1'b1;
    busy_window(cnt);
    n_tests++;
    if (cnt != DEPTH || Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_window got=%0d ready=%b want=%0d ready=1",
               cnt, Ready, DEPTH);
    end
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model_op(1'b0, 2'd0, 1'b0, BASE + 32'(4*i), '0, erv, eadel, eades, erd);
      issue(1'b0, 2'd0, 1'b0, BASE + 32'(4*i), '0);
      n_tests++;
      if (RValid !== erv || AdEL !== eadel || RD !== erd) begin
        n_fail++;
        $display("FAIL cleared_word%0d got rv=%b el=%b rd=%h want rv=%b rd=%h",
                 i, RValid, AdEL, RD, erv, erd);
      end
    end
    idle();
  endtask

  task automatic test_subword();
    logic erv, eadel, eades;
    logic [31:0] erd;
    model_op(1'b1, 2'd0, 1'b0, 32'h10, 32'h1234_5678, erv, eadel, eades, erd);
    issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h1234_5678);
    n_tests++;
    if (RValid !== 1'b0 || AdES !== 1'b0) begin
      n_fail++;
      $display("FAIL store_word got rv=%b es=%b want 0 0", RValid, AdES);
    end
    model_op(1'b0, 2'd2, 1'b0, 32'h11, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd2, 1'b0, 32'h11, '0);
    n_tests++;
    if (RValid !== 1'b1 || RD !== erd) begin
      n_fail++;
      $display("FAIL load_byte_zx got rv=%b rd=%h want 1 %h", RValid, RD, erd);
    end
    model_op(1'b1, 2'd2, 1'b0, 32'h13, 32'h0000_009A, erv, eadel, eades, erd);
    issue(1'b1, 2'd2, 1'b0, 32'h13, 32'h0000_009A);
    model_op(1'b0, 2'd1, 1'b1, 32'h12, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd1, 1'b1, 32'h12, '0);
    n_tests++;
    if (RValid !== 1'b1 || RD !== erd) begin
      n_fail++;
      $display("FAIL load_half_sx got rv=%b rd=%h want 1 %h", RValid, RD, erd);
    end
    idle();
    n_tests++;
    if (RValid !== 1'b0 || RD !== erd) begin
      n_fail++;
      $display("FAIL rd_hold got rv=%b rd=%h want 0 %h", RValid, RD, erd);
    end
  endtask

  task automatic test_errors();
    logic erv, eadel, eades;
    logic [31:0] erd;
    model_op(1'b0, 2'd0, 1'b0, 32'h02, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd0, 1'b0, 32'h02, '0);
    n_tests++;
    if ({RValid, AdEL, AdES} !== {erv, eadel, eades} || RD !== erd) begin
      n_fail++;
      $display("FAIL misaligned_load got rv=%b el=%b rd=%h want %b %b %h",
               RValid, AdEL, RD, erv, eadel, erd);
    end
    model_op(1'b1, 2'd1, 1'b0, 32'h05, 32'hFFFF, erv, eadel, eades, erd);
    issue(1'b1, 2'd1, 1'b0, 32'h05, 32'hFFFF);
    n_tests++;
    if ({RValid, AdEL, AdES} !== {erv, eadel, eades}) begin
      n_fail++;
      $display("FAIL misaligned_store got rv=%b el=%b es=%b want %b%b%b",
               RValid, AdEL, AdES, erv, eadel, eades);
    end
    idle();
    n_tests++;
    if (AdES !== 1'b0) begin
      n_fail++;
      $display("FAIL ades_pulse got=%b want=0", AdES);
    end
    model_op(1'b0, 2'd0, 1'b0, 32'h04, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd0, 1'b0, 32'h04, '0);
    n_tests++;
    if (RValid !== 1'b1 || RD !== erd) begin
      n_fail++;
      $display("FAIL word_unchanged got rd=%h want %h", RD, erd);
    end
    idle();
  endtask

  task automatic test_boundary();
    logic erv, eadel, eades;
    logic [31:0] erd;
    logic [31:0] top;
    logic [31:0] d;
    top = BASE + 32'(4*DEPTH);
    d = $urandom;
    model_op(1'b1, 2'd0, 1'b0, top, d, erv, eadel, eades, erd);
    issue(1'b1, 2'd0, 1'b0, top, d);
    n_tests++;
    if (AdES !== eades || RValid !== erv) begin
      n_fail++;
      $display("FAIL store_oob got es=%b rv=%b want %b %b",
               AdES, RValid, eades, erv);
    end
    model_op(1'b1, 2'd0, 1'b0, top - 4, d, erv, eadel, eades, erd);
    issue(1'b1, 2'd0, 1'b0, top - 4, d);
    n_tests++;
    if (AdES !== eades) begin
      n_fail++;
      $display("FAIL store_last got es=%b want %b", AdES, eades);
    end
    model_op(1'b0, 2'd0, 1'b0, top - 4, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd0, 1'b0, top - 4, '0);
    n_tests++;
    if (RValid !== 1'b1 || AdEL !== 1'b0 || RD !== erd) begin
      n_fail++;
      $display("FAIL load_last got rv=%b el=%b rd=%h want 1 0 %h",
               RValid, AdEL, RD, erd);
    end
    model_op(1'b0, 2'd2, 1'b0, top, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd2, 1'b0, top, '0);
    n_tests++;
    if ({RValid, AdEL} !== {erv, eadel} || RD !== erd) begin
      n_fail++;
      $display("FAIL load_oob got rv=%b el=%b rd=%h want %b %b %h",
               RValid, AdEL, RD, erv, eadel, erd);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic erv, eadel, eades;
    logic [31:0] erd;
    Req = 1'b1;
    WE = 1'b0;
    Size = 2'd0;
    Addr = 32'h10;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    Req = 1'b0;
    Reset = 1'b1;
    n_tests++;
    if (RValid !== 1'b0 || AdEL !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_drop got rv=%b el=%b busy=%b want 0 0 1",
               RValid, AdEL, Busy);
    end
    busy_window(cnt);
    n_tests++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL reclear_window got=%0d want=%0d", cnt, DEPTH);
    end
    model_clear();
    model_op(1'b0, 2'd0, 1'b0, 32'h10, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd0, 1'b0, 32'h10, '0);
    n_tests++;
    if (RValid !== 1'b1 || RD !== erd) begin
      n_fail++;
      $display("FAIL reclear_data got rv=%b rd=%h want 1 %h", RValid, RD, erd);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic erv, eadel, eades;
    logic [31:0] erd;
    model_op(1'b1, 2'd0, 1'b0, 32'h20, 32'hDEAD_BEEF, erv, eadel, eades, erd);
    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'hDEAD_BEEF);
    n_tests++;
    if (RValid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_store got rv=%b want 0", RValid);
    end
    model_op(1'b0, 2'd0, 1'b0, 32'h20, '0, erv, eadel, eades, erd);
    issue(1'b0, 2'd0, 1'b0, 32'h20, '0);
    n_tests++;
    if (RValid !== 1'b1 || RD !== erd) begin
      n_fail++;
      $display("FAIL b2b_load got rv=%b rd=%h want 1 %h", RValid, RD, erd);
    end
    idle();
  endtask

  task automatic test_random();
    logic erv, eadel, eades;
    logic [31:0] erd;
    logic we, sg;
    logic [1:0] sz;
    logic [31:0] a, wd;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle();
        n_tests++;
        if ({RValid, AdEL, AdES} !== 3'b000 || RD !== last_rd) begin
          n_fail++;
          $display("FAIL rand_idle%0d got rv=%b el=%b es=%b rd=%h want 000 %h",
                   it, RValid, AdEL, AdES, RD, last_rd);
        end
      end else begin
        we = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        a  = ($urandom_range(0, 19) == 0) ? $urandom
                                          : 32'($urandom_range(0, 79));
        wd = $urandom;
        model_op(we, sz, sg, a, wd, erv, eadel, eades, erd);
        issue(we, sz, sg, a, wd);
        n_tests++;
        if ({RValid, AdEL, AdES} !== {erv, eadel, eades} || RD !== erd) begin
          n_fail++;
          $display("FAIL rand_op%0d we=%b sz=%0d a=%h got %b%b%b rd=%h want %b%b%b rd=%h",
                   it, we, sz, a, RValid, AdEL, AdES, RD,
                   erv, eadel, eades, erd);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_subword();
    test_errors();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised successor data memory for the pipelined CPU, sitting in the MEM stage behind the ALU address path.
- Adds internal byte-lane generation from access size, sign/zero-extended sub-word loads and registered read with a valid strobe.
- Adds alignment/range exception flags and a sequential clear engine, so large FPGA block-RAM depths need no single-cycle clear.
- Requests use a Req/Ready handshake; the clear engine owns the array after reset.

Parameters:
- DEPTH_LOG2, 11, log2 of word count; DEPTH = 2**DEPTH_LOG2 words of 32 bits.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4*DEPTH aligned.
- TRACE_EN, 1, enables the simulation write trace line.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset, sampled at posedge Clock.
- Req  in  1  request valid.
- Ready  out  1  block accepts a request this cycle.
- WE  in  1  1 = store, 0 = load.
- Size  in  2  0 = word, 1 = halfword, 2 = byte, 3 = reserved (treated as word).
- SignRead  in  1  sign-extend sub-word loads.
- Addr  in  32  byte address.
- WD  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- WPC  in  32  PC of the store, trace only.
- RD  out  32  load data, extended to 32 bits.
- RValid  out  1  RD/exception valid, one-cycle pulse.
- AdEL  out  1  load address error, pulses with RValid.
- AdES  out  1  store address error, pulses one cycle after accept.
- Busy  out  1  clear engine running.

Behaviour:
- **States.** CLEAR and IDLE.
- **Reset.** Reset==0 at posedge forces CLEAR, clear counter 0, and RD, RValid, AdEL, AdES = 0. Busy=1 and Ready=0 from the next cycle.
- **CLEAR.** Writes 0 to word[counter] each cycle and increments the counter.
  - When the counter reaches DEPTH-1 and that word is written, go to IDLE.
  - Busy=1 for exactly DEPTH cycles after reset releases.
- **Reset mid-CLEAR or mid-request.** Restarts the clear at word 0. Any pending RValid or error pulse is dropped.
- **IDLE.** Ready=1 and Busy=0. A request is accepted on a posedge with Req&&Ready. There is one request per cycle and no internal queue.
- **Range and alignment.**
  - Word index = (Addr-BASE_ADDR)[DEPTH_LOG2+1:2].
  - In range means BASE_ADDR <= Addr < BASE_ADDR+4*DEPTH.
  - Misaligned means word with Addr[1:0]!=0, or half with Addr[0]!=0.
- **Store.**
  - Lane mask: word 1111; half 0011<<Addr[1:0]; byte 0001<<Addr[1:0].
  - Lane data = WD << {Addr[1:0],3'b0}. Unmasked bytes keep their old value.
  - The commit happens on the accepting edge.
  - An illegal store (out of range or misaligned) writes nothing. AdES=1 for one cycle after acceptance; RValid stays 0.
  - Legal stores never raise RValid.
- **Load.**
  - Array read on the accepting edge; RD/RValid registered, so latency is 1 cycle.
  - Sub-word is extracted at Addr[1:0] and zero- or sign-extended per SignRead.
  - A load accepted in the cycle after a store to the same word returns the new data; no bypass is needed.
  - An illegal load gives RValid=1, AdEL=1, RD=0.
- **Outputs when idle.** RD holds its last value when RValid=0. RValid, AdEL and AdES are 0 in all cycles without a completion.
- **Trace.** With TRACE_EN, each legal store prints "%d@%h: *%h <= %h" with time, WPC, word-aligned Addr and the merged word.

Test Plan:
- Reset low 1 cycle with DEPTH_LOG2=4 → Busy=1 and Ready=0 for exactly 16 cycles, then Ready=1. Loads of words 0..15 return 0.
- Store word 32'h1234_5678 @0x10, then load byte @0x11:
  - SignRead=0 → RD=32'h0000_0056.
  - Store byte 8'h9A @0x13, then load half @0x12 with SignRead=1 → RD=32'hFFFF_9A34.
- Load word @0x02 → RValid=AdEL=1, RD=0. Store half @0x05 → AdES=1 and the memory word is unchanged.
- Store @BASE+4*DEPTH → AdES=1, no write. Store @BASE+4*DEPTH-4 → written; a following read returns it.
- Reset asserted on the cycle a load is accepted → no RValid. Clear restarts at word 0 and the full DEPTH-cycle Busy window repeats.
- Back-to-back store 0xDEAD_BEEF @0x20 and load @0x20 → RValid on the cycle after the load with RD=32'hDEAD_BEEF. Exactly one trace line is printed.
